// File: rtl/gcd_operand_loader.sv
// Byte-stream feeder for the subtractive GCD: packs two LE 32-bit operands.
// Optional zero-operand rejection when GCD_LOADER_ZERO_CHECK_EN is defined.
module gcd_operand_loader #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] din1,
  output logic [31:0] din2,
  output logic        din_rdy,
  input  logic        dout_rdy,
  output logic        busy,
  output logic        timeout,
  output logic        err_zero
);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    ISSUE,
    WAIT
  } state_t;

  localparam int WDW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST =
    WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     a_q, a_d;
  logic [23:0]     b_q, b_d;
  logic [31:0]     din1_q, din1_d;
  logic [31:0]     din2_q, din2_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            dout_rdy_q;
  logic            to_q, to_d;
  logic            ez_q, ez_d;

  logic            accept;
  logic            done;
  logic            expire;
  logic            zero_hit;
  logic [31:0]     b_full;

  assign s_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept  = s_valid && s_ready;
  assign done    = dout_rdy && !dout_rdy_q;
  assign expire  = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
  // B is only complete together with the byte arriving now
  assign b_full  = {s_data, b_q};

`ifdef GCD_LOADER_ZERO_CHECK_EN
  assign zero_hit = (a_q == 32'd0) || (b_full == 32'd0);
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    din1_d  = din1_q;
    din2_d  = din2_q;
    wd_d    = wd_q;
    to_d    = 1'b0;
    ez_d    = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        if (accept) begin
          a_d[{cnt_q, 3'b000} +: 8] = s_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (accept) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q != 2'd3) begin
            b_d[{cnt_q, 3'b000} +: 8] = s_data;
          end else if (zero_hit) begin
            state_d = LOAD_A;
            ez_d    = 1'b1;
          end else begin
            state_d = ISSUE;
            din1_d  = a_q;
            din2_d  = b_full;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (done) begin
          state_d = LOAD_A;
        end else if (expire) begin
          state_d = LOAD_A;
          to_d    = 1'b1;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      din1_q     <= '0;
      din2_q     <= '0;
      wd_q       <= '0;
      dout_rdy_q <= 1'b0;
      to_q       <= 1'b0;
      ez_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      din1_q     <= din1_d;
      din2_q     <= din2_d;
      wd_q       <= wd_d;
      dout_rdy_q <= dout_rdy;
      to_q       <= to_d;
      ez_q       <= ez_d;
    end
  end

  assign din1     = din1_q;
  assign din2     = din2_q;
  assign din_rdy  = (state_q == ISSUE);
  assign busy     = (state_q == ISSUE) || (state_q == WAIT);
  assign timeout  = to_q;
  assign err_zero = ez_q;

endmodule

// File: tb/tb_gcd_operand_loader.sv
// Directed + randomized bench for gcd_operand_loader.
// Operands are round-tripped through the byte stream and compared.
module tb_gcd_operand_loader;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] din1, din2;
  logic        din_rdy;
  logic        dout_rdy = 1'b0;
  logic        busy, timeout, err_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int n_issue = 0;
  int exp_issue = 0;
  logic [31:0] exp_d1 = 0, exp_d2 = 0;
`ifdef GCD_LOADER_ZERO_CHECK_EN
  bit zchk = 1'b1;
`else
  bit zchk = 1'b0;
`endif

  gcd_operand_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .din1(din1), .din2(din2), .din_rdy(din_rdy),
    .dout_rdy(dout_rdy), .busy(busy),
    .timeout(timeout), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (din_rdy) n_issue++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int t;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_data  = b;
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("byte_accept_bound", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // returns in the cycle after the 8th byte is accepted
  task automatic send_pair(input logic [31:0] a,
                           input logic [31:0] b,
                           input int maxgap);
    for (int k = 0; k < 4; k++)
      send_byte(8'((a >> (8 * k)) & 32'hff), maxgap);
    for (int k = 0; k < 4; k++)
      send_byte(8'((b >> (8 * k)) & 32'hff), maxgap);
    s_valid = 1'b0;
  endtask

  task automatic expect_issue(input string tag,
                              input logic [31:0] a,
                              input logic [31:0] b);
    if (zchk && (a == 0 || b == 0)) begin
      check({tag, "_rdy"}, din_rdy, 1'b0);
      check({tag, "_ez"}, err_zero, 1'b1);
      check({tag, "_sr"}, s_ready, 1'b1);
      check({tag, "_d1"}, din1, exp_d1);
      check({tag, "_d2"}, din2, exp_d2);
    end else begin
      exp_d1 = a;
      exp_d2 = b;
      exp_issue++;
      check({tag, "_rdy"}, din_rdy, 1'b1);
      check({tag, "_ez"}, err_zero, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_d1"}, din1, a);
      check({tag, "_d2"}, din2, b);
    end
  endtask

  task automatic complete(input string tag, input int lat);
    repeat (lat) @(negedge clk);
    dout_rdy = 1'b1;
    @(negedge clk);
    check({tag, "_done_sr"}, s_ready, 1'b1);
    check({tag, "_done_busy"}, busy, 1'b0);
    dout_rdy = 1'b0;
  endtask

  initial begin
    int first, seen;
    logic sr_at;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sready", s_ready, 1'b1);
    check("rst_din1", din1, 32'd0);
    check("rst_din2", din2, 32'd0);
    check("rst_dinrdy", din_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_errzero", err_zero, 1'b0);

    send_pair(32'd48, 32'd18, 0);
    expect_issue("b2b", 32'd48, 32'd18);
    check("b2b_sr_issue", s_ready, 1'b0);
    @(negedge clk);
    check("b2b_strobe_1cyc", din_rdy, 1'b0);
    repeat (3) @(negedge clk);
    check("b2b_sr_wait", s_ready, 1'b0);
    complete("b2b", 0);
    check("b2b_hold_d1", din1, 32'd48);

    send_pair(32'd48, 32'd18, 5);
    expect_issue("gap", 32'd48, 32'd18);
    complete("gap", 2);

    dout_rdy = 1'b1;
    send_pair(32'h0000_00c4, 32'h0000_0007, 0);
    expect_issue("stale", 32'h0000_00c4, 32'h0000_0007);
    repeat (3) @(negedge clk);
    check("stale_busy", busy, 1'b1);
    dout_rdy = 1'b0;
    repeat (7) @(negedge clk);
    check("stale_still_wait", s_ready, 1'b0);
    complete("stale", 0);

    send_byte(8'haa, 0);
    send_byte(8'hbb, 0);
    send_byte(8'hcc, 0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_sready", s_ready, 1'b1);
    check("mrst_din1", din1, 32'd0);
    check("mrst_dinrdy", din_rdy, 1'b0);
    exp_d1 = 0;
    exp_d2 = 0;
    send_pair(32'h0000_0100, 32'h0000_0040, 0);
    expect_issue("mrst", 32'd256, 32'd64);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("wrst_busy", busy, 1'b0);
    check("wrst_sready", s_ready, 1'b1);
    check("wrst_din1", din1, 32'd0);
    check("wrst_din2", din2, 32'd0);
    exp_d1 = 0;
    exp_d2 = 0;

    send_pair(32'h1234_5678, 32'h9abc_def0, 0);
    expect_issue("tmo", 32'h1234_5678, 32'h9abc_def0);
    first = 0;
    seen = 0;
    sr_at = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (timeout) begin
        seen++;
        if (first == 0) begin
          first = k;
          sr_at = s_ready;
        end
      end
    end
    check("tmo_cycle", first, TMO + 1);
    check("tmo_pulses", seen, 1);
    check("tmo_sready", sr_at, 1'b1);

    send_pair(32'd0, 32'd5, 0);
    expect_issue("zero", 32'd0, 32'd5);
    if (!zchk) complete("zero", 1);
    @(negedge clk);
    check("zero_ez_1cyc", err_zero, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 4) rb = 0;
      if (i % 7 == 3) ra = ra & 32'h0000_00ff;
      send_pair(ra, rb, 3);
      expect_issue("rnd", ra, rb);
      if (din_rdy) complete("rnd", int'($urandom_range(8, 1)));
    end

    repeat (4) @(negedge clk);
    check("issue_count", n_issue, exp_issue);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_operand_loader.md
# gcd_operand_loader

Upstream feeder for the subtractive GCD unit. Accepts a byte stream over a valid/ready handshake, assembles two 32-bit little-endian operands and presents them on the GCD's `din1`/`din2` with a one-cycle `din_rdy` strobe. It then holds the operands and throttles the stream until the GCD signals completion on `dout_rdy`, or until a watchdog expires.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum WAIT cycles before abort; 0 disables the watchdog.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_data`  in  8  operand byte stream.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `din1`  out  32  operand A to GCD.
- `din2`  out  32  operand B to GCD.
- `din_rdy`  out  1  one-cycle strobe: operands valid, start GCD.
- `dout_rdy`  in  1  GCD completion level from the GCD unit.
- `busy`  out  1  high in ISSUE and WAIT.
- `timeout`  out  1  one-cycle pulse: watchdog abort.
- `err_zero`  out  1  one-cycle pulse: zero operand rejected (see Configuration).

## Operation
- States:
  - LOAD_A: collect 4 bytes into A.
  - LOAD_B: collect 4 bytes into B.
  - ISSUE: `din_rdy`=1 for exactly one cycle.
  - WAIT: await completion.
- Byte accepted on a rising edge where `s_valid && s_ready`. `s_ready` = 1 only in LOAD_A and LOAD_B.
- A 2-bit byte counter selects the lane. Byte k of an operand is written to bits [8k+7:8k], so the first byte is the LSB. The counter wraps 3→0 on the state change.
- LOAD_A → LOAD_B after the 4th accepted A byte. LOAD_B → ISSUE after the 4th accepted B byte.
- `din1`/`din2` are registered copies of A/B. They update only on the ISSUE entry edge and stay stable through WAIT and until the next ISSUE.
- ISSUE → WAIT unconditionally.
- Completion = rising edge of `dout_rdy`: `dout_rdy`=1 and registered `dout_rdy_q`=0. It is evaluated only in WAIT.
  - A `dout_rdy` level already high at ISSUE (stale result) is not completion.
  - On completion, WAIT → LOAD_A.
- Watchdog: counter cleared on WAIT entry, incremented each WAIT cycle. If it reaches `TIMEOUT_CYCLES` without completion, go to LOAD_A and pulse `timeout`.
  - If completion and expiry occur in the same cycle, completion wins and there is no `timeout`.
- Bytes presented while `s_ready`=0 are not consumed. The upstream source holds them.

## Timing
- Reset values: state LOAD_A, `s_ready`=1 (the cycle after reset), `din1`=`din2`=0, `din_rdy`=0, `busy`=0, `timeout`=0, `err_zero`=0, byte counter 0, `dout_rdy_q`=0, watchdog 0.
- 8th byte accepted at edge N: `din_rdy`=1 and new `din1`/`din2` are visible in cycle N+1. `busy`=1 from cycle N+1.
- Completion edge detected at edge M: `s_ready`=1 and `busy`=0 in cycle M+1.
- Minimum pair-to-pair period: 8 byte cycles + ISSUE + GCD latency + 1.
- `timeout` and `err_zero` are high for exactly one cycle, coincident with the first LOAD_A cycle.
- Reset mid-operation, in any state: the partial operand is discarded, all registers return to reset values, and no `din_rdy` is emitted.

## Configuration
- `GCD_LOADER_ZERO_CHECK_EN` defined:
  - On the 4th B byte, if A==0 or B==0 (B checked including the incoming byte), go to LOAD_A instead of ISSUE.
  - Pulse `err_zero`. No `din_rdy`; `din1`/`din2` are unchanged.
  - Purpose: prevents the subtractive GCD from looping forever.
- Not defined: zero operands are issued normally, and `err_zero` is constant 0.

## Test plan
- Bytes 30,00,00,00,12,00,00,00 (hex) back-to-back:
  - `din1`=48 and `din2`=18, with `din_rdy` high one cycle.
  - `s_ready`=0 until a `dout_rdy` 0→1 edge, then `s_ready`=1 the next cycle.
- Same bytes with random `s_valid` gaps (0–5 cycles) → identical `din1`/`din2` and a single `din_rdy`. No byte is lost or duplicated.
- `dout_rdy` held 1 across ISSUE, dropped, then re-raised 7 cycles later → only the re-rise completes WAIT.
- `TIMEOUT_CYCLES`=16, `dout_rdy` held 0 → `timeout` pulses once, 16 WAIT cycles after ISSUE, and `s_ready` returns to 1.
- With the macro, bytes 00×4 then 05,00,00,00 → `err_zero` pulse, no `din_rdy`, `din1`/`din2` unchanged. Without the macro → `din_rdy` with `din1`=0, `din2`=5.
- `rst` after 3 A bytes, then 8 fresh bytes encoding A=0x0000_0100, B=0x0000_0040 → `din1`=256, `din2`=64. No stale bytes are merged.
